// File: rtl/rv32_wb_port_arbiter_if.sv
// Writeback bus between the two result producers, the arbiter and the integer
// register file write port.
interface rv32_wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            p0_valid_in;
  logic [4:0]      p0_addr_in;
  logic [XLEN-1:0] p0_data_in;
  logic            p0_ready_out;

  logic            p1_valid_in;
  logic [4:0]      p1_addr_in;
  logic [XLEN-1:0] p1_data_in;
  logic            p1_ready_out;

  logic            rf_wr_eb_out;
  logic [4:0]      rf_rd_addr_out;
  logic [XLEN-1:0] rf_rd_out;
  logic            p1_aged_out;

  // Requester / observer side
  modport master (
    output p0_valid_in, p0_addr_in, p0_data_in,
    output p1_valid_in, p1_addr_in, p1_data_in,
    input  p0_ready_out, p1_ready_out,
    input  rf_wr_eb_out, rf_rd_addr_out, rf_rd_out, p1_aged_out
  );

  // Arbiter side
  modport slave (
    input  p0_valid_in, p0_addr_in, p0_data_in,
    input  p1_valid_in, p1_addr_in, p1_data_in,
    output p0_ready_out, p1_ready_out,
    output rf_wr_eb_out, rf_rd_addr_out, rf_rd_out, p1_aged_out
  );
endinterface

// File: rtl/rv32_wb_port_arbiter.sv
// Arbitrates the single integer register file write port between the load unit
// (P0, fixed priority) and the ALU (P1), with aging so P1 cannot starve.
module rv32_wb_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = 4
) (
  input  logic                  mp_clk_in,
  input  logic                  mp_rst_in,
  rv32_wb_port_arbiter_if.slave bus
);

  typedef enum logic {
    PRIO0 = 1'b0,
    AGED1 = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t            state;
  logic              aged;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              p0_ready;
  logic              p1_ready;
  logic              wr_eb;
  logic [4:0]        wr_addr;
  logic [XLEN-1:0]   wr_data;

  // Grants are combinational so a requester sees its accept in the same cycle.
  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (!mp_rst_in) begin
      if (state == AGED1) begin
        p1_ready = bus.p1_valid_in;
        p0_ready = bus.p0_valid_in & ~bus.p1_valid_in;
      end else begin
        p0_ready = bus.p0_valid_in;
        p1_ready = bus.p1_valid_in & ~bus.p0_valid_in;
      end
    end
  end

  always_comb begin
    wait_nxt = wait_cnt;
    if (!bus.p1_valid_in || p1_ready) begin
      wait_nxt = '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge mp_clk_in) begin
    if (mp_rst_in) begin
      state    <= PRIO0;
      aged     <= 1'b0;
      wait_cnt <= '0;
      wr_eb    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      unique case (state)
        PRIO0: begin
          if (wait_nxt == MAX_CNT) begin
            state <= AGED1;
            aged  <= 1'b1;
          end
        end
        AGED1: begin
          // A dropped P1 request also ends aging; nothing is flagged for it.
          if (p1_ready || !bus.p1_valid_in) begin
            state <= PRIO0;
            aged  <= 1'b0;
          end
        end
      endcase

      // x0 writes are consumed here but never reach the register file.
      if (p0_ready) begin
        wr_eb   <= (bus.p0_addr_in != 5'd0);
        wr_addr <= bus.p0_addr_in;
        wr_data <= bus.p0_data_in;
      end else if (p1_ready) begin
        wr_eb   <= (bus.p1_addr_in != 5'd0);
        wr_addr <= bus.p1_addr_in;
        wr_data <= bus.p1_data_in;
      end else begin
        wr_eb   <= 1'b0;
      end
    end
  end

  assign bus.p0_ready_out   = p0_ready;
  assign bus.p1_ready_out   = p1_ready;
  assign bus.rf_wr_eb_out   = wr_eb;
  assign bus.rf_rd_addr_out = wr_addr;
  assign bus.rf_rd_out      = wr_data;
  assign bus.p1_aged_out    = aged;

endmodule

// File: tb/tb_rv32_wb_port_arbiter.sv
// Scoreboard bench for rv32_wb_port_arbiter: the driver predicts grants from a
// stall-count model and queues the expected register file writes.
module tb_rv32_wb_port_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 3;
  localparam int WAIT_W   = 4;

  typedef struct {
    int          due;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rv32_wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

  rv32_wb_port_arbiter #(
    .XLEN     (XLEN),
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) dut (
    .mp_clk_in (clk),
    .mp_rst_in (rst),
    .bus       (bus)
  );

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b0;
  bit          aged_en = 1'b0;
  int          stall  = 0;
  bit          acc0   = 1'b0;
  bit          acc1   = 1'b0;
  logic        seen0;
  logic        seen1;
  logic [4:0]  last_addr;
  logic [31:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  // One clock of stimulus; the reference model predicts grants from how long
  // P1 has been kept waiting and queues what the register file should see.
  task automatic applyStimulus(input bit r,
                               input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                               input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bit   aged;
    bit   e0;
    bit   e1;
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.p0_valid_in = v0;
    bus.p0_addr_in  = a0;
    bus.p0_data_in  = d0;
    bus.p1_valid_in = v1;
    bus.p1_addr_in  = a1;
    bus.p1_data_in  = d1;
    @(negedge clk);
    aged = (stall >= MAX_WAIT);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!r) begin
      if (v1 && (aged || !v0)) e1 = 1'b1;
      else if (v0)             e0 = 1'b1;
    end
    seen0 = bus.p0_ready_out;
    seen1 = bus.p1_ready_out;
    checkValue("p0_ready", 32'(seen0), 32'(e0));
    checkValue("p1_ready", 32'(seen1), 32'(e1));
    if (aged_en) checkValue("p1_aged", 32'(bus.p1_aged_out), 32'(aged));
    if (r) begin
      e = '{due: cyc + 1, we: 1'b0, addr: 5'd0, data: 32'd0};
      exp_q.push_back(e);
    end else if (e0) begin
      e = '{due: cyc + 1, we: (a0 != 5'd0), addr: a0, data: d0};
      exp_q.push_back(e);
    end else if (e1) begin
      e = '{due: cyc + 1, we: (a1 != 5'd0), addr: a1, data: d1};
      exp_q.push_back(e);
    end
    stall = (r || !v1 || e1) ? 0 : stall + 1;
    acc0 = e0;
    acc1 = e1;
  endtask

  // Write port monitor: a queued write due this cycle must appear, otherwise
  // the enable is low and address/data keep the last issued values.
  task automatic checkOutput();
    bit   exp_we;
    exp_t e;
    exp_we = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      exp_we    = e.we;
      last_addr = e.addr;
      last_data = e.data;
    end
    checkValue("rf_wr_eb",   32'(bus.rf_wr_eb_out),   32'(exp_we));
    checkValue("rf_rd_addr", 32'(bus.rf_rd_addr_out), 32'(last_addr));
    checkValue("rf_rd",      bus.rf_rd_out,           last_data);
  endtask

  always @(negedge clk) begin
    if (mon_en) checkOutput();
  end

  initial begin
    bit          r0v;
    bit          r1v;
    logic [4:0]  r0a;
    logic [4:0]  r1a;
    logic [31:0] r0d;
    logic [31:0] r1d;
    logic [4:0]  pa;
    bit          got;
    int          grant_cyc;

    bus.p0_valid_in = 1'b0;
    bus.p0_addr_in  = '0;
    bus.p0_data_in  = '0;
    bus.p1_valid_in = 1'b0;
    bus.p1_addr_in  = '0;
    bus.p1_data_in  = '0;

    $display("[TB] reset with both requesters valid");
    applyStimulus(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    #1;
    mon_en  = 1'b1;
    aged_en = 1'b1;
    applyStimulus(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);

    $display("[TB] single P1 write");
    applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF);
    checkValue("single_p1_ready", 32'(seen1), 32'd1);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    $display("[TB] contention and aging");
    pa = 5'd1;
    got = 1'b0;
    grant_cyc = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      applyStimulus(0, 1, pa, 32'h1000 + 32'(pa), 1, 5'd7, 32'hA5A50007);
      if (acc0) pa = pa + 5'd1;
      if (seen1 === 1'b1) begin
        got = 1'b1;
        grant_cyc = i;
      end
    end
    checkValue("aging_grant_cycle", 32'(grant_cyc), 32'd4);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, pa, 32'h1000 + 32'(pa), 0, 5'd0, 32'h0);
      if (acc0) pa = pa + 5'd1;
    end

    $display("[TB] P1 drops its request while stalled");
    applyStimulus(0, 1, 5'd10, 32'hA, 1, 5'd11, 32'hB);
    applyStimulus(0, 1, 5'd12, 32'hC, 1, 5'd11, 32'hB);
    applyStimulus(0, 1, 5'd13, 32'hD, 0, 5'd0, 32'h0);
    got = 1'b0;
    grant_cyc = 0;
    pa = 5'd14;
    for (int i = 1; i <= 8 && !got; i++) begin
      applyStimulus(0, 1, pa, 32'h2000 + 32'(pa), 1, 5'd11, 32'hB);
      if (acc0) pa = pa + 5'd1;
      if (seen1 === 1'b1) begin
        got = 1'b1;
        grant_cyc = i;
      end
    end
    checkValue("aging_after_drop", 32'(grant_cyc), 32'd4);

    $display("[TB] x0 write is consumed but not issued");
    applyStimulus(0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'h0);
    checkValue("x0_p0_ready", 32'(seen0), 32'd1);
    applyStimulus(0, 1, 5'd3, 32'h3333, 0, 5'd0, 32'h0);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    $display("[TB] back-to-back P0 writes");
    for (int a = 1; a <= 4; a++) begin
      applyStimulus(0, 1, 5'(a), 32'h100 + 32'(a), 0, 5'd0, 32'h0);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    $display("[TB] reset coinciding with a P1 request");
    applyStimulus(1, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99999999);
    checkValue("reset_p1_ready", 32'(seen1), 32'd0);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    $display("[TB] randomized traffic");
    r0v = 1'b0;
    r1v = 1'b0;
    r0a = '0;
    r1a = '0;
    r0d = '0;
    r1d = '0;
    for (int i = 0; i < 400; i++) begin
      bit r;
      if (!r0v || acc0) begin
        r0v = ($urandom_range(0, 9) < 6);
        r0a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r0d = $urandom;
      end
      if (!r1v || acc1) begin
        r1v = ($urandom_range(0, 9) < 5);
        r1a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        r1d = $urandom;
      end
      r = ($urandom_range(0, 63) == 0);
      applyStimulus(r, r0v, r0a, r0d, r1v, r1a, r1d);
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    end
    checkValue("queue_drained", 32'(exp_q.size()), 32'd0);

    #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
